// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side handshake bundle for fifo_wr_arbiter.
// master = requesters + FIFO model side, slave = the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 16
);
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         req_last;
    logic [NREQ-1:0][DW-1:0] req_data;
    logic [NREQ-1:0]         ack;
    logic                    fifo_full;
    logic                    fifo_wr;
    logic [DW-1:0]           fifo_din;

    modport master (
        output req, req_last, req_data, fifo_full,
        input  ack, fifo_wr, fifo_din
    );

    modport slave (
        input  req, req_last, req_data, fifo_full,
        output ack, fifo_wr, fifo_din
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet-locking write arbiter in front of sync_fifo.
// Optional beat limit per packet enabled by defining BURST_LIMIT_EN.
module fifo_wr_arbiter_lane #(
    parameter int DW = 16
) (
    input  logic          ack,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] dout
);
    assign dout = ack ? data : '0;
endmodule

module fifo_wr_arbiter #(
    parameter  int NREQ      = 4,
    parameter  int DW        = 16,
    parameter  int MAX_BURST = 8,
    localparam int OW        = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fifo_wr_arbiter_if.slave       bus,
    output logic                   busy,
    output logic [OW-1:0]          owner,
    output logic                   burst_err
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                  state;
    logic [OW-1:0]           rr_ptr;
    logic [OW-1:0]           win;
    logic [OW:0]             scan;
    logic                    any_req;
    logic [NREQ-1:0]         ack;
    logic [NREQ-1:0][DW-1:0] lane_dout;
    logic [DW-1:0]           din;

`ifdef BURST_LIMIT_EN
    localparam int CW = $clog2(MAX_BURST + 1);
    logic [CW-1:0] beat_cnt;
`endif

    function automatic logic [OW-1:0] nxt(input logic [OW-1:0] p);
        return (p == OW'(NREQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // Scan downwards so the requester closest to rr_ptr is written last and wins.
    always_comb begin
        win     = '0;
        scan    = '0;
        any_req = |bus.req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan = {1'b0, rr_ptr} + (OW+1)'(k);
            if (scan >= (OW+1)'(NREQ))
                scan = scan - (OW+1)'(NREQ);
            if (bus.req[scan[OW-1:0]])
                win = scan[OW-1:0];
        end
    end

    // Reset gates the grant so a held req cannot sneak a write through IDLE.
    always_comb begin
        ack = '0;
        if (rst_n && !bus.fifo_full) begin
            if (state == IDLE) begin
                if (any_req)
                    ack[win] = 1'b1;
            end else begin
                ack[owner] = bus.req[owner];
            end
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        fifo_wr_arbiter_lane #(.DW(DW)) u_lane (
            .ack  (ack[i]),
            .data (bus.req_data[i]),
            .dout (lane_dout[i])
        );
    end

    always_comb begin
        din = '0;
        for (int i = 0; i < NREQ; i++)
            din = din | lane_dout[i];
    end

    assign bus.ack      = ack;
    assign bus.fifo_wr  = |ack;
    assign bus.fifo_din = din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            busy   <= 1'b0;
`ifdef BURST_LIMIT_EN
            beat_cnt  <= '0;
            burst_err <= 1'b0;
`endif
        end else begin
`ifdef BURST_LIMIT_EN
            burst_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|ack) begin
                        owner <= win;
                        if (bus.req_last[win]) begin
                            rr_ptr <= nxt(win);
                        end else begin
                            state <= LOCKED;
                            busy  <= 1'b1;
`ifdef BURST_LIMIT_EN
                            beat_cnt <= CW'(1);
`endif
                        end
                    end
                end
                LOCKED: begin
                    if (|ack) begin
`ifdef BURST_LIMIT_EN
                        if (beat_cnt != CW'(MAX_BURST))
                            beat_cnt <= beat_cnt + 1'b1;
`endif
                        if (bus.req_last[owner]) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            rr_ptr <= nxt(owner);
                        end
`ifdef BURST_LIMIT_EN
                        // Beat limit reached: release and let the rest re-arbitrate.
                        else if (beat_cnt == CW'(MAX_BURST - 1)) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            rr_ptr    <= nxt(owner);
                            burst_err <= 1'b1;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef BURST_LIMIT_EN
    assign burst_err = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester beat tables and an 8-deep FIFO model.
module tb_fifo_wr_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [1:0] owner;
    logic       burst_err;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .owner     (owner),
        .burst_err (burst_err)
    );

    int n_chk = 0;
    int n_pass = 0;

    logic [16:0] bm [NREQ][32];
    int          bn [NREQ];
    int          bp [NREQ];
    logic [15:0] wlog [64];
    int          wn, fcnt, cyc;
    bit          full_en, rd_req, ovf;

    logic [3:0]  ack_s;
    logic        wr_s, full_s, busy_s;
    logic [15:0] din_s;
    logic [1:0]  owner_s;
    logic [3:0]  ack_h [128];
    logic        busy_h [128];
    logic        berr_h [128];
    logic [15:0] exp6 [11];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic push(input int r, input logic [15:0] d, input logic last);
        bm[r][bn[r]] = {last, d};
        bn[r]++;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++)
            if (bp[i] < bn[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive_in();
        for (int i = 0; i < NREQ; i++) begin
            if (bp[i] < bn[i]) begin
                bus.req[i]      = 1'b1;
                bus.req_last[i] = bm[i][bp[i]][16];
                bus.req_data[i] = bm[i][bp[i]][15:0];
            end else begin
                bus.req[i]      = 1'b0;
                bus.req_last[i] = 1'b0;
                bus.req_data[i] = '0;
            end
        end
        bus.fifo_full = full_en && (fcnt >= 8);
    endtask

    task automatic sample_out();
        ack_s   = bus.ack;
        wr_s    = bus.fifo_wr;
        din_s   = bus.fifo_din;
        full_s  = bus.fifo_full;
        busy_s  = busy;
        owner_s = owner;
        if (cyc < 128) begin
            ack_h[cyc]  = ack_s;
            busy_h[cyc] = busy_s;
            berr_h[cyc] = burst_err;
        end
    endtask

    task automatic commit();
        for (int i = 0; i < NREQ; i++)
            if (ack_s[i] && bp[i] < bn[i]) bp[i]++;
        if (wr_s) begin
            if (full_s) ovf = 1'b1;
            if (wn < 64) wlog[wn] = din_s;
            wn++;
            if (full_en) fcnt++;
        end
        if (rd_req) begin
            if (fcnt > 0) fcnt--;
            rd_req = 1'b0;
        end
        cyc++;
    endtask

    task automatic step();
        drive_in();
        #1;
        sample_out();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic run(input string tag, input int maxc);
        int k;
        k = 0;
        while (!all_empty() && k < maxc) begin
            step();
            k++;
        end
        chk(tag, {31'd0, all_empty()}, 32'd1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            bn[i] = 0;
            bp[i] = 0;
        end
        for (int i = 0; i < 64; i++) wlog[i] = '0;
        wn = 0; fcnt = 0; cyc = 0;
        full_en = 1'b0; rd_req = 1'b0; ovf = 1'b0;
        drive_in();
        @(posedge clk);
        #1;
        chk("rst_outs", {7'd0, bus.ack, bus.fifo_wr, bus.fifo_din, busy, owner, burst_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [15:0] exp);
        chk($sformatf("%s_w%0d", tag, idx), {16'd0, wlog[idx]}, {16'd0, exp});
    endtask

    initial begin
        int bsum, first2, bcnt;

        // idle after reset
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("idle_c%0d", c), {24'd0, ack_s, wr_s, busy_s, owner_s}, 32'd0);
        end

        // single-beat round robin
        apply_reset();
        push(0, 16'h0000, 1'b1); push(0, 16'h0001, 1'b1);
        push(1, 16'h0010, 1'b1); push(1, 16'h0011, 1'b1);
        push(2, 16'h0020, 1'b1);
        push(3, 16'h0030, 1'b1);
        run("rr_drain", 40);
        chk("rr_count", wn, 6);
        chk_log("rr", 0, 16'h0000); chk_log("rr", 1, 16'h0010);
        chk_log("rr", 2, 16'h0020); chk_log("rr", 3, 16'h0030);
        chk_log("rr", 4, 16'h0001); chk_log("rr", 5, 16'h0011);
        chk("rr_ack0", {28'd0, ack_h[0]}, 32'h1);
        chk("rr_ack3", {28'd0, ack_h[3]}, 32'h8);
        chk("rr_owner", {30'd0, owner}, 32'd1);

        // packet lock vs competing single beat
        apply_reset();
        push(0, 16'hA001, 1'b0); push(0, 16'hA002, 1'b0); push(0, 16'hA003, 1'b1);
        push(2, 16'hC001, 1'b1);
        run("lock_drain", 40);
        chk("lock_count", wn, 4);
        chk_log("lock", 0, 16'hA001); chk_log("lock", 1, 16'hA002);
        chk_log("lock", 2, 16'hA003); chk_log("lock", 3, 16'hC001);
        bsum = 0; first2 = -1;
        for (int c = 0; c < cyc && c < 128; c++) begin
            if (busy_h[c] === 1'b1) bsum++;
            if (first2 < 0 && ack_h[c][2] === 1'b1) first2 = c;
        end
        chk("lock_busy_cycles", bsum, 2);
        chk("lock_first_ack2", first2, 3);
        chk("lock_owner", {30'd0, owner}, 32'd2);

        // FIFO fills mid-packet on req1
        apply_reset();
        full_en = 1'b1;
        for (int b = 1; b <= 10; b++) push(1, 16'hB000 + 16'(b), b == 10);
        for (int c = 0; c < 8; c++) step();
        chk("full_wn8", wn, 8);
        chk_log("full", 7, 16'hB008);
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("full_hold_c%0d", c), {26'd0, ack_s, wr_s, busy_s}, 32'h1);
        end
        rd_req = 1'b1;
        step();
        chk("full_rd_cycle_wr", {31'd0, wr_s}, 32'd0);
        step();
        chk("full_resume", {12'd0, ack_s, din_s}, {12'd0, 4'b0010, 16'hB009});
        rd_req = 1'b1;
        step();
        step();
        chk("full_last", {16'd0, din_s}, 32'hB00A);
        chk("full_no_ovf", {31'd0, ovf}, 32'd0);
        chk("full_wn10", wn, 10);
        chk("full_busy_end", {31'd0, busy}, 32'd0);

        // async reset in beat 2 of a req3 packet
        apply_reset();
        push(3, 16'hD001, 1'b0); push(3, 16'hD002, 1'b0);
        push(3, 16'hD003, 1'b0); push(3, 16'hD004, 1'b1);
        step();
        drive_in();
        #1;
        sample_out();
        chk("arst_pre", {26'd0, ack_s, wr_s, busy_s}, {26'd0, 4'b1000, 1'b1, 1'b1});
        #2;
        rst_n = 1'b0;
        #1;
        sample_out();
        chk("arst_drop", {24'd0, ack_s, wr_s, busy_s, owner_s}, 32'd0);
        @(posedge clk);
        commit();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(0, 16'hE001, 1'b1);
        run("arst_drain", 40);
        chk("arst_count", wn, 5);
        chk_log("arst", 0, 16'hD001); chk_log("arst", 1, 16'hE001);
        chk_log("arst", 2, 16'hD002); chk_log("arst", 3, 16'hD003);
        chk_log("arst", 4, 16'hD004);

        // 10-beat packet on req0 with req1 waiting
        apply_reset();
        for (int b = 1; b <= 10; b++) push(0, 16'hF000 + 16'(b), b == 10);
        push(1, 16'h1111, 1'b1);
`ifdef BURST_LIMIT_EN
        exp6 = '{16'hF001, 16'hF002, 16'hF003, 16'hF004, 16'hF005, 16'hF006,
                 16'hF007, 16'hF008, 16'h1111, 16'hF009, 16'hF00A};
        bcnt = 1;
`else
        exp6 = '{16'hF001, 16'hF002, 16'hF003, 16'hF004, 16'hF005, 16'hF006,
                 16'hF007, 16'hF008, 16'hF009, 16'hF00A, 16'h1111};
        bcnt = 0;
`endif
        run("burst_drain", 60);
        chk("burst_count", wn, 11);
        for (int k = 0; k < 11; k++) chk_log("burst", k, exp6[k]);
        bsum = 0;
        for (int c = 0; c < cyc && c < 128; c++)
            if (berr_h[c] === 1'b1) bsum++;
        chk("burst_err_pulses", bsum, bcnt);
`ifdef BURST_LIMIT_EN
        chk("burst_err_c8", {31'd0, berr_h[8]}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-locking write arbiter that lets NREQ requesters share the write port of one sync_fifo (16-bit data, wr/fifo_full interface).
- Sits directly in front of sync_fifo. Its fifo_wr and fifo_din outputs drive the FIFO's wr and data_in inputs, and it obeys the FIFO's fifo_full flag.
- Once a requester is granted, it owns the port until its last beat is written, so packets are never interleaved in the FIFO.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 16, data width; must match sync_fifo data width
MAX_BURST, 8, beat limit per packet; used only with BURST_LIMIT_EN

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester beat valid; held until acked
req_last  input  NREQ  marks the final beat of a packet
req_data  input  NREQ*DW  requester i data at bits [i*DW +: DW]
ack  output  NREQ  one-hot; beat of requester i accepted this cycle
fifo_full  input  1  from sync_fifo
fifo_wr  output  1  to sync_fifo wr
fifo_din  output  DW  to sync_fifo data_in
busy  output  1  high while a packet lock is held (LOCKED state)
owner  output  $clog2(NREQ)  current or last granted requester index
burst_err  output  1  forced-release pulse (BURST_LIMIT_EN only; otherwise tied 0)

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, busy=0, burst_err=0. With no req: ack=0, fifo_wr=0, fifo_din=0.
- Reset is asynchronous. Asserting it mid-packet drops the lock immediately and writes nothing further. The requester re-arbitrates after reset.
- Handshake:
  - Zero-latency valid/ready.
  - ack, fifo_wr and fifo_din are combinational from req, req_data, state and fifo_full.
  - fifo_wr = |ack.
  - fifo_din = req_data of the acked requester, or 0 when there is no ack.
  - At most one ack bit is set per cycle.
- IDLE state:
  - If any req is set and fifo_full=0, choose the winner w as the first set req scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Assert ack[w] and set owner<=w.
  - If req_last[w]=1: stay in IDLE and set rr_ptr<=(w+1)%NREQ.
  - Otherwise go to LOCKED with beat_cnt<=1.
  - If fifo_full=1: no ack, no state change.
- LOCKED state:
  - Only owner may be acked. ack[owner] = req[owner] & ~fifo_full.
  - Each acked beat increments beat_cnt.
  - When an acked beat carries req_last[owner]: go to IDLE and set rr_ptr<=(owner+1)%NREQ.
  - If the owner drops req or the FIFO is full: no write, lock held indefinitely. Other requesters stay blocked.
- fifo_full is sampled the same cycle. The arbiter never asserts fifo_wr while fifo_full=1, so sync_fifo overflow is impossible.
- req_last without req is ignored.
- Fairness: each requester gets at least one packet per NREQ packets while it keeps requesting.
- beat_cnt width is $clog2(MAX_BURST+1) and saturates.

Optional Feature:
BURST_LIMIT_EN
- Defined:
  - When a beat is acked in LOCKED with beat_cnt==MAX_BURST-1 and req_last=0, the beat is still written.
  - The arbiter then forces IDLE, advances rr_ptr past owner, and pulses burst_err for 1 cycle (registered; asserted the cycle after that beat).
  - The requester's remaining beats re-arbitrate as a new packet.
- Undefined:
  - No beat limit, and the lock is held until req_last.
  - burst_err is a constant 0.
  - beat_cnt logic may be removed.

Test Plan:
- Reset then release; all req=0 for 5 cycles -> fifo_wr=0, ack=0, busy=0, owner=0 throughout.
- req=4'b1111, all single-beat (req_last=1), data_i=16'h00i0+n, FIFO never full -> acks in order 0,1,2,3,0,1; FIFO read-back shows the same order.
- Req0 3-beat packet (16'hA001..A003) and req2 1-beat packet (16'hC001) raised in the same cycle -> A001, A002, A003 written before C001; busy=1 for 2 cycles; ack[2] is first seen the cycle after A003.
- Fill the 8-deep FIFO to full mid-packet on req1, hold 4 cycles, then issue one rd -> fifo_wr=0 and ack=0 while full; packet resumes with the next beat after rd; no fifo_overflow.
- Assert rst_n=0 asynchronously (between edges) during beat 2 of a 4-beat req3 packet -> busy, ack and fifo_wr drop immediately; after release, rr_ptr=0 and req3's retry competes normally.
- With BURST_LIMIT_EN and MAX_BURST=8, req0 sends 10 beats with no req_last while req1 waits -> 8 beats written, burst_err pulses once, req1 is granted next, and req0's remaining 2 beats follow.
